pipe_ctrl: RTL and testbench

//  Sequencing/hazard controller for the 3-stage 16-bit pipeline (IF -> ID -> IE).

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_cnt.sv | 28 ++
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 3-stage pipeline sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        StFill,
        StRun,
        StStall,
        StHalt
    } state_e;

    localparam logic [3:0]  OP_HALT   = 4'hF;
    localparam logic [3:0]  OP_NOP    = 4'h0;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing/hazard controller for the IF -> ID -> IE pipeline: fill, stall, flush, halt, forward.
// Define PIPE_STEP_EN to add the single-step input (halt after every retired instruction).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FILL_CYCLES = 2,
    parameter logic [3:0]  OP_HALT     = pipe_pkg::OP_HALT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode_ie,
    input  logic [3:0]       rd_ie,
    input  logic             we_ie,
    input  logic             ie_busy,
    input  logic             br_taken,
    input  logic [3:0]       rs1_id,
    input  logic [3:0]       rs2_id,
    input  logic             resume,
`ifdef PIPE_STEP_EN
    input  logic             step,
`endif
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             fwd1_sel,
    output logic             fwd2_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

`ifdef PIPE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
    logic go;
    assign go = resume | step;
`else
    localparam bit STEP_MODE = 1'b0;
    logic go;
    assign go = resume;
`endif

    state_e            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              fill_done;
    logic              retire_en;
    logic              stall_en;

    assign fill_done = (32'(fill_q) + 32'd1) >= FILL_CYCLES;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFill;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        unique case (state_q)
            StFill: begin
                if (fill_done) begin
                    state_d = StRun;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            StRun: begin
                if (ie_busy) begin
                    state_d = StStall;
                end else if (!br_taken && (opcode_ie == OP_HALT)) begin
                    state_d = StHalt;
                end else if (STEP_MODE && retire_en) begin
                    state_d = StHalt;
                end
            end
            StStall: begin
                // The stalled op retires on exit, so step mode parks in HALT.
                if (!ie_busy) begin
                    state_d = STEP_MODE ? StHalt : StRun;
                end
            end
            StHalt: begin
                if (go) begin
                    state_d = StRun;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        fwd1_sel   = 1'b0;
        fwd2_sel   = 1'b0;
        retire_en  = 1'b0;
        stall_en   = 1'b0;
        if (rst) begin
            unique case (state_q)
                StRun: begin
                    if (!ie_busy) begin
                        if (br_taken) begin
                            pc_we      = 1'b1;
                            ifid_we    = 1'b1;
                            ifid_flush = 1'b1;
                            retire_en  = (opcode_ie != OP_NOP);
                        end else begin
                            fwd1_sel  = we_ie & (rd_ie == rs1_id);
                            fwd2_sel  = we_ie & (rd_ie == rs2_id);
                            retire_en = (opcode_ie != OP_NOP);
                            if (opcode_ie != OP_HALT) begin
                                pc_we   = 1'b1;
                                ifid_we = 1'b1;
                            end
                        end
                    end
                end
                StStall: begin
                    stall_en = 1'b1;
                    if (!ie_busy) begin
                        retire_en = 1'b1;
                        if (br_taken) begin
                            pc_we      = 1'b1;
                            ifid_we    = 1'b1;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = rst && (state_q == StHalt);

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (!rst),
        .en   (stall_en),
        .count(stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_retire_cnt (
        .clk  (clk),
        .clr  (!rst),
        .en   (retire_en),
        .count(retire_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; honours PIPE_STEP_EN when defined.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode_ie, rd_ie, rs1_id, rs2_id;
    logic        we_ie, ie_busy, br_taken, resume;
    logic        step;
    logic        pc_we, ifid_we, ifid_flush, fwd1_sel, fwd2_sel, halted;
    logic [15:0] stall_cnt, retire_cnt;

    int total = 0;
    int bad   = 0;
    int exp_retire = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FILL_CYCLES(2),
        .OP_HALT    (4'hF),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode_ie (opcode_ie),
        .rd_ie     (rd_ie),
        .we_ie     (we_ie),
        .ie_busy   (ie_busy),
        .br_taken  (br_taken),
        .rs1_id    (rs1_id),
        .rs2_id    (rs2_id),
        .resume    (resume),
`ifdef PIPE_STEP_EN
        .step      (step),
`endif
        .pc_we     (pc_we),
        .ifid_we   (ifid_we),
        .ifid_flush(ifid_flush),
        .fwd1_sel  (fwd1_sel),
        .fwd2_sel  (fwd2_sel),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .retire_cnt(retire_cnt)
    );

    // Advance one clock; inputs change 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        opcode_ie = 4'h0; rd_ie = 4'h0; rs1_id = 4'h0; rs2_id = 4'h0;
        we_ie = 1'b0; ie_busy = 1'b0; br_taken = 1'b0; resume = 1'b0; step = 1'b0;
    endtask

    // Release reset and wait out the fill window so the next cycle is RUN.
    task automatic release_to_run();
        rst = 1'b1;
        tick();
        tick();
        exp_retire = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        #1;
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rst_pc_we: got %b want 0", pc_we); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        total++; if (retire_cnt !== 16'd0) begin bad++; $display("FAIL rst_retire_cnt: got %0d want 0", retire_cnt); end
        rst = 1'b1;
        #1;
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL fill1_pc_we: got %b want 0", pc_we); end
        tick();
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL fill2_pc_we: got %b want 0", pc_we); end
        tick();
        total++; if (pc_we !== 1'b1) begin bad++; $display("FAIL run_pc_we: got %b want 1", pc_we); end
        total++; if (ifid_we !== 1'b1) begin bad++; $display("FAIL run_ifid_we: got %b want 1", ifid_we); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL run_halted: got %b want 0", halted); end
        exp_retire = 0;
    endtask

    task automatic test_forward();
        rd_ie = 4'd2; we_ie = 1'b1; rs1_id = 4'd2; rs2_id = 4'd2;
        #1;
        total++; if ({fwd1_sel, fwd2_sel} !== 2'b11) begin bad++; $display("FAIL fwd_both: got %b want 11", {fwd1_sel, fwd2_sel}); end
        we_ie = 1'b0;
        #1;
        total++; if ({fwd1_sel, fwd2_sel} !== 2'b00) begin bad++; $display("FAIL fwd_no_we: got %b want 00", {fwd1_sel, fwd2_sel}); end
        we_ie = 1'b1; rs2_id = 4'd3;
        #1;
        total++; if ({fwd1_sel, fwd2_sel} !== 2'b10) begin bad++; $display("FAIL fwd_rs1_only: got %b want 10", {fwd1_sel, fwd2_sel}); end
        rd_ie = 4'd0; rs1_id = 4'd7; rs2_id = 4'd0;
        #1;
        total++; if ({fwd1_sel, fwd2_sel} !== 2'b01) begin bad++; $display("FAIL fwd_r0: got %b want 01", {fwd1_sel, fwd2_sel}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall();
        opcode_ie = 4'h3; we_ie = 1'b1; rd_ie = 4'd5; rs1_id = 4'd5;
        for (int i = 0; i < 4; i++) begin
            ie_busy = 1'b1;
            #1;
            total++; if ({pc_we, ifid_we} !== 2'b00) begin bad++; $display("FAIL stall_en_%0d: got %b want 00", i, {pc_we, ifid_we}); end
            total++; if (fwd1_sel !== 1'b0) begin bad++; $display("FAIL stall_fwd_%0d: got %b want 0", i, fwd1_sel); end
            tick();
        end
        ie_busy = 1'b0;
        #1;
        total++; if (retire_cnt !== 16'(exp_retire)) begin bad++; $display("FAIL stall_no_retire: got %0d want %0d", retire_cnt, exp_retire); end
        tick();
        exp_retire++;
        opcode_ie = 4'h0;
        #1;
        total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
        total++; if (retire_cnt !== 16'(exp_retire)) begin bad++; $display("FAIL stall_retire: got %0d want %0d", retire_cnt, exp_retire); end
        total++; if (pc_we !== 1'b1) begin bad++; $display("FAIL stall_resume_pc_we: got %b want 1", pc_we); end
        total++; if (fwd1_sel !== 1'b1) begin bad++; $display("FAIL stall_resume_fwd: got %b want 1", fwd1_sel); end
        idle_inputs();
        tick();
    endtask

    task automatic test_branch();
        br_taken = 1'b1; opcode_ie = 4'h2; we_ie = 1'b1; rd_ie = 4'd4; rs1_id = 4'd4;
        #1;
        total++; if ({pc_we, ifid_we, ifid_flush} !== 3'b111) begin bad++; $display("FAIL br_flush: got %b want 111", {pc_we, ifid_we, ifid_flush}); end
        total++; if (fwd1_sel !== 1'b0) begin bad++; $display("FAIL br_fwd: got %b want 0", fwd1_sel); end
        tick();
        exp_retire++;
        idle_inputs();
        #1;
        total++; if ({pc_we, ifid_flush} !== 2'b10) begin bad++; $display("FAIL br_after: got %b want 10", {pc_we, ifid_flush}); end
        total++; if (retire_cnt !== 16'(exp_retire)) begin bad++; $display("FAIL br_retire: got %0d want %0d", retire_cnt, exp_retire); end
        tick();
    endtask

    task automatic test_halt();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        total++; if ({halted, pc_we} !== 2'b01) begin bad++; $display("FAIL resume_ignored: got %b want 01", {halted, pc_we}); end
        opcode_ie = 4'hF;
        #1;
        total++; if ({halted, pc_we, ifid_we} !== 3'b000) begin bad++; $display("FAIL halt_op: got %b want 000", {halted, pc_we, ifid_we}); end
        tick();
        exp_retire++;
        opcode_ie = 4'h0;
        #1;
        total++; if ({halted, pc_we} !== 2'b10) begin bad++; $display("FAIL halt_entered: got %b want 10", {halted, pc_we}); end
        total++; if (retire_cnt !== 16'(exp_retire)) begin bad++; $display("FAIL halt_retire: got %0d want %0d", retire_cnt, exp_retire); end
        tick();
        total++; if ({halted, pc_we} !== 2'b10) begin bad++; $display("FAIL halt_hold: got %b want 10", {halted, pc_we}); end
        resume = 1'b1;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_resume_cycle: got %b want 1", halted); end
        tick();
        resume = 1'b0;
        #1;
        total++; if ({halted, pc_we} !== 2'b01) begin bad++; $display("FAIL halt_resumed: got %b want 01", {halted, pc_we}); end
    endtask

    task automatic test_reset_in_halt();
        opcode_ie = 4'hF;
        tick();
        opcode_ie = 4'h0;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL rh_halted: got %b want 1", halted); end
        rst = 1'b0;
        tick();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rh_halted_clr: got %b want 0", halted); end
        total++; if ({stall_cnt, retire_cnt} !== 32'd0) begin bad++; $display("FAIL rh_counters: got %0d/%0d want 0/0", stall_cnt, retire_cnt); end
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rh_pc_we: got %b want 0", pc_we); end
        release_to_run();
    endtask

    task automatic test_reset_in_stall();
        ie_busy = 1'b1; opcode_ie = 4'h3;
        tick();
        tick();
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL rs_stall_cnt: got %0d want 1", stall_cnt); end
        rst = 1'b0;
        tick();
        total++; if ({stall_cnt, retire_cnt} !== 32'd0) begin bad++; $display("FAIL rs_counters: got %0d/%0d want 0/0", stall_cnt, retire_cnt); end
        idle_inputs();
        rst = 1'b1;
        #1;
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rs_fill1: got %b want 0", pc_we); end
        tick();
        total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rs_fill2: got %b want 0", pc_we); end
        tick();
        total++; if (pc_we !== 1'b1) begin bad++; $display("FAIL rs_run: got %b want 1", pc_we); end
        exp_retire = 0;
    endtask

    task automatic test_step();
        opcode_ie = 4'h3;
        tick();
        exp_retire++;
        opcode_ie = 4'h0;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL step_first_halt: got %b want 1", halted); end
        for (int i = 0; i < 2; i++) begin
            step = 1'b1; opcode_ie = 4'h3;
            tick();
            step = 1'b0;
            #1;
            total++; if (halted !== 1'b0) begin bad++; $display("FAIL step_run_%0d: got %b want 0", i, halted); end
            tick();
            exp_retire++;
            opcode_ie = 4'h0;
            #1;
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL step_halt_%0d: got %b want 1", i, halted); end
            total++; if (retire_cnt !== 16'(exp_retire)) begin bad++; $display("FAIL step_retire_%0d: got %0d want %0d", i, retire_cnt, exp_retire); end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
`ifdef PIPE_STEP_EN
        test_step();
`else
        test_stall();
        test_branch();
        test_halt();
        test_reset_in_halt();
        test_reset_in_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
